// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter and sequencer sharing one square-root calculator among N_REQ
// requesters; launches it, guards the done pulse with a watchdog, returns a tagged root.
module sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_radicand,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       sqrt_start,
    output logic [WIDTH-1:0]           sqrt_radicand,
    input  logic                       sqrt_done,
    input  logic [WIDTH/2-1:0]         sqrt_root,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH/2-1:0]         rsp_root,
    output logic                       rsp_timeout,
    output logic                       fault,
    output logic                       busy,
    output logic [2:0]                 dbg_state
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high. Once rsp_valid rises, rsp_id/rsp_root/rsp_timeout stay frozen until then.
    // req_ready is a one-hot grant shown only in IDLE; the granted radicand is taken
    // on that same edge.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_radicand;
    logic               r_start;
    logic [CNT_W-1:0]   r_wd_cnt;
    logic [WIDTH/2-1:0] r_root;
    logic               r_timeout;
    logic               r_rsp_valid;
    logic               r_fault;

    logic               w_grant_any;
    logic [ID_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]   w_grant_rad;
    logic [ID_W-1:0]    w_ptr_next;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // First asserted request at or after the pointer, searching upward with wrap.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_grant_any && req_valid[wrap_idx(r_ptr, k)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = wrap_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_grant_rad = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == w_grant_idx) w_grant_rad = req_radicand[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_grant_any && !rst) req_ready[w_grant_idx] = 1'b1;
    end

    assign w_ptr_next = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_radicand  <= '0;
            r_start     <= 1'b0;
            r_wd_cnt    <= '0;
            r_root      <= '0;
            r_timeout   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_radicand <= w_grant_rad;
                        r_id       <= w_grant_idx;
                        r_start    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start  <= 1'b0;
                    r_wd_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A done pulse wins over a watchdog expiry landing on the same cycle.
                    if (sqrt_done) begin
                        r_root      <= sqrt_root;
                        r_timeout   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_root      <= '0;
                        r_timeout   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        if (r_timeout) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                // After a timeout the calculator may still answer late; park until reset.
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sqrt_start    = r_start;
    assign sqrt_radicand = r_radicand;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_id;
    assign rsp_root      = r_root;
    assign rsp_timeout   = r_timeout;
    assign fault         = r_fault;
    assign busy          = (r_state != S_IDLE);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: timeline model of the arbiter, per-cycle compare,
// response scoreboard and hand-computed literal expectations.
module tb_sqrt_arbiter;
    localparam int N_REQ   = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;
    localparam int IDW     = 2;
    localparam int SBW     = 1 + IDW + WIDTH/2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_radicand;
    logic [N_REQ-1:0]       req_ready;
    logic                   sqrt_start;
    logic [WIDTH-1:0]       sqrt_radicand;
    logic                   sqrt_done = 1'b0;
    logic [WIDTH/2-1:0]     sqrt_root = '0;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH/2-1:0]     rsp_root;
    logic                   rsp_timeout;
    logic                   fault;
    logic                   busy;
    logic [2:0]             dbg_state;

    sqrt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_radicand(req_radicand), .req_ready(req_ready),
        .sqrt_start(sqrt_start), .sqrt_radicand(sqrt_radicand),
        .sqrt_done(sqrt_done), .sqrt_root(sqrt_root),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_root(rsp_root), .rsp_timeout(rsp_timeout),
        .fault(fault), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: run still going at cycle %0d, required finish before 50000", cyc);
        $fatal(1, "bench stopped");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- calculator stand-in ----------------
    bit calc_en  = 1;
    int calc_lat = 5;

    function automatic logic [WIDTH/2-1:0] isqrt_table(input logic [WIDTH-1:0] r);
        case (r)
            32'd144:        return 16'd12;
            32'd16:         return 16'd4;
            32'd81:         return 16'd9;
            32'd1000000:    return 16'd1000;
            32'hFFFF_FFFF:  return 16'd65535;
            32'd49:         return 16'd7;
            32'd9:          return 16'd3;
            32'd10000:      return 16'd100;
            default:        return 16'hBAD0;
        endcase
    endfunction

    always begin
        logic [WIDTH-1:0] r;
        @(negedge clk);
        if (calc_en && sqrt_start === 1'b1) begin
            r = sqrt_radicand;
            repeat (calc_lat) @(posedge clk);
            #1;
            sqrt_done = 1'b1;
            sqrt_root = isqrt_table(r);
            @(posedge clk);
            #1;
            sqrt_done = 1'b0;
        end
    end

    // ---------------- model, scoreboard and monitor ----------------
    bit               m_op    = 0;
    bit               m_pend  = 0;
    bit               m_fault = 0;
    bit               m_to    = 0;
    int               m_tacc  = 0;
    logic [IDW-1:0]   m_ptr   = '0;
    logic [IDW-1:0]   m_id    = '0;
    logic [WIDTH-1:0] m_rad   = '0;
    logic [WIDTH/2-1:0] m_root = '0;
    logic [SBW-1:0]   exp_q[$];

    int grant_ids[$];
    logic [N_REQ-1:0] grant_rr_last;
    int grant_cyc = 0;
    int start_cyc = 0;
    int rise_cyc  = 0;
    bit prev_rv   = 0;
    int n_hs      = 0;
    int hs_ids[$];
    logic [IDW-1:0]     hs_id;
    logic [WIDTH/2-1:0] hs_root;
    logic               hs_to;

    always @(negedge clk) begin
        int pick;
        int j;
        logic [N_REQ-1:0] e_rr;
        bit in_wait;
        logic [SBW-1:0] e;

        pick = -1;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(m_ptr) + k) % N_REQ;
            if (pick < 0 && req_valid[j]) pick = j;
        end
        e_rr = '0;
        if (!m_op && !m_fault && !rst && pick >= 0) e_rr[pick] = 1'b1;
        in_wait = m_op && !m_pend && (cyc >= m_tacc + 2);

        if (chk_en) begin
            check("req_ready", req_ready, e_rr);
            check("sqrt_start", sqrt_start, m_op && !m_pend && (cyc == m_tacc + 1));
            check("busy", busy, m_op || m_fault);
            check("fault", fault, m_fault);
            check("rsp_valid", rsp_valid, m_pend);
            if (m_op && !m_pend && cyc >= m_tacc + 1) check("sqrt_radicand", sqrt_radicand, m_rad);
            if (m_pend) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_root", rsp_root, m_root);
                check("rsp_timeout", rsp_timeout, m_to);
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rsp", {rsp_timeout, rsp_id, rsp_root}, e);
                end
                hs_id   = rsp_id;
                hs_root = rsp_root;
                hs_to   = rsp_timeout;
                hs_ids.push_back(int'(rsp_id));
                n_hs++;
            end
        end

        if (req_ready !== '0 && chk_en) begin
            for (int k = 0; k < N_REQ; k++) if (req_ready[k]) grant_ids.push_back(k);
            grant_rr_last = req_ready;
            grant_cyc = cyc;
        end
        if (sqrt_start === 1'b1) start_cyc = cyc;
        if (rsp_valid === 1'b1 && !prev_rv) rise_cyc = cyc;
        prev_rv = (rsp_valid === 1'b1);

        // advance the model across the coming edge
        if (rst) begin
            m_op = 0; m_pend = 0; m_fault = 0; m_ptr = '0;
            exp_q.delete();
        end else if (!m_op) begin
            if (!m_fault && pick >= 0) begin
                m_op   = 1;
                m_tacc = cyc;
                m_id   = IDW'(pick);
                m_rad  = req_radicand[pick*WIDTH +: WIDTH];
            end
        end else if (in_wait) begin
            if (sqrt_done) begin
                m_pend = 1; m_root = sqrt_root; m_to = 0;
                exp_q.push_back({1'b0, m_id, sqrt_root});
            end else if (cyc == m_tacc + 1 + TIMEOUT) begin
                m_pend = 1; m_root = '0; m_to = 1;
                exp_q.push_back({1'b1, m_id, 16'd0});
            end
        end else if (m_pend && rsp_ready) begin
            m_ptr = IDW'((int'(m_id) + 1) % N_REQ);
            if (m_to) m_fault = 1;
            m_op = 0;
            m_pend = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_rad(input int i, input logic [WIDTH-1:0] v);
        req_radicand[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_grants(input int target, input string name);
        int n = 0;
        while (grant_ids.size() < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_grant_seen"}, grant_ids.size() >= target, 1);
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (n_hs < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_rsp_seen"}, n_hs >= target, 1);
    endtask

    task automatic reset_literals(input string name);
        check({name, "_req_ready"}, req_ready, 0);
        check({name, "_sqrt_start"}, sqrt_start, 0);
        check({name, "_sqrt_radicand"}, sqrt_radicand, 0);
        check({name, "_rsp_valid"}, rsp_valid, 0);
        check({name, "_rsp_id"}, rsp_id, 0);
        check({name, "_rsp_root"}, rsp_root, 0);
        check({name, "_rsp_timeout"}, rsp_timeout, 0);
        check({name, "_fault"}, fault, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gb;
        int hb;
        int exp_order[5];
        logic [N_REQ-1:0] seen;
        logic [IDW-1:0] id0;
        logic [WIDTH/2-1:0] root0;
        logic to0;

        rst = 1'b1; req_valid = '0; req_radicand = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        reset_literals("reset");
        @(posedge clk); #1;

        // single request from requester 2, done five cycles after start
        calc_lat = 5;
        set_rad(2, 32'd144);
        gb = grant_ids.size(); hb = n_hs;
        req_valid = 4'b0100;
        wait_grants(gb + 1, "single");
        req_valid = '0;
        wait_hs(hb + 1, "single");
        check("single_grant_id", grant_ids[gb], 2);
        check("single_req_ready", grant_rr_last, 4'b0100);
        check("single_start_lat", start_cyc - grant_cyc, 1);
        check("single_rsp_lat", rise_cyc - grant_cyc, 7);
        check("single_rsp_id", hs_id, 2);
        check("single_rsp_root", hs_root, 12);
        check("single_rsp_timeout", hs_to, 0);

        // all four requesters held valid from a fresh pointer
        pulse_rst();
        calc_lat = 2;
        set_rad(0, 32'd16); set_rad(1, 32'd81); set_rad(2, 32'd1000000); set_rad(3, 32'hFFFF_FFFF);
        gb = grant_ids.size(); hb = n_hs;
        req_valid = 4'b1111;
        wait_grants(gb + 5, "rr");
        req_valid = '0;
        wait_hs(hb + 5, "rr");
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check($sformatf("rr_order_%0d", i), grant_ids[gb + i], exp_order[i]);
        seen = '0;
        for (int i = 0; i < 4; i++) seen[hs_ids[hb + i]] = 1'b1;
        check("rr_each_once", seen, 4'b1111);
        check("rr_last_root", hs_root, 4);

        // response back-pressure with another request pending
        calc_lat = 3;
        set_rad(1, 32'd49); set_rad(3, 32'd9);
        rsp_ready = 1'b0;
        gb = grant_ids.size(); hb = n_hs;
        req_valid = 4'b1010;
        wait_grants(gb + 1, "bp");
        req_valid = 4'b1000;
        for (int n = 0; n < 50 && rsp_valid !== 1'b1; n++) @(negedge clk);
        if (rsp_valid !== 1'b1) @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 1);
        id0 = rsp_id; root0 = rsp_root; to0 = rsp_timeout;
        check("bp_id", id0, 1);
        check("bp_root", root0, 7);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_fields", {rsp_timeout, rsp_id, rsp_root}, {to0, id0, root0});
            check("bp_no_grant", req_ready, 0);
            check("bp_no_start", sqrt_start, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_grants(gb + 2, "bp_next");
        req_valid = '0;
        check("bp_next_id", grant_ids[gb + 1], 3);
        wait_hs(hb + 2, "bp");
        check("bp_next_root", hs_root, 3);

        // calculator never answers: watchdog, then sticky fault
        calc_en = 0;
        set_rad(0, 32'd4); set_rad(2, 32'd144);
        gb = grant_ids.size(); hb = n_hs;
        req_valid = 4'b0101;
        wait_grants(gb + 1, "to");
        check("to_grant_id", grant_ids[gb], 0);
        wait_hs(hb + 1, "to");
        check("to_rsp_lat", rise_cyc - grant_cyc, TIMEOUT + 2);
        check("to_flag", hs_to, 1);
        check("to_root", hs_root, 0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("to_fault", fault, 1);
            check("to_no_grant", req_ready, 0);
            check("to_busy", busy, 1);
        end
        @(posedge clk); #1;
        req_valid = '0;

        // reset during WAIT, stray done afterwards, then a normal request
        pulse_rst();
        calc_en = 1; calc_lat = 6;
        gb = grant_ids.size(); hb = n_hs;
        req_valid = 4'b0100;
        wait_grants(gb + 1, "abort");
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_in_wait_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        reset_literals("abort");
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
            check("abort_idle", busy, 0);
        end
        @(posedge clk); #1;
        check("abort_no_hs", n_hs, hb);
        calc_lat = 2;
        set_rad(0, 32'd16);
        gb = grant_ids.size();
        req_valid = 4'b0001;
        wait_grants(gb + 1, "after_abort");
        req_valid = '0;
        wait_hs(hb + 1, "after_abort");
        check("after_abort_id", hs_id, 0);
        check("after_abort_root", hs_root, 4);

        // done lands on the same cycle the watchdog would expire
        calc_lat = TIMEOUT;
        set_rad(1, 32'd10000);
        gb = grant_ids.size(); hb = n_hs;
        req_valid = 4'b0010;
        wait_grants(gb + 1, "tie");
        req_valid = '0;
        wait_hs(hb + 1, "tie");
        check("tie_rsp_lat", rise_cyc - grant_cyc, TIMEOUT + 2);
        check("tie_root", hs_root, 100);
        check("tie_timeout", hs_to, 0);
        @(negedge clk);
        check("tie_fault", fault, 0);

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
